// File: rtl/risc_v_exec_issue_lite_pkg.sv
// Shared constants, FSM encoding and instruction field helpers for the exec/issue block.
package risc_v_exec_issue_lite_pkg;

  localparam logic [6:0] OP_IMM        = 7'b0010011;
  localparam logic [6:0] OP            = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_EXEC_W,
    S_WB,
    S_FAULT
  } state_t;

  function automatic logic [4:0] rs1_f(input logic [31:0] i);
    return i[19:15];
  endfunction

  function automatic logic [4:0] rs2_f(input logic [31:0] i);
    return i[24:20];
  endfunction

  function automatic logic [4:0] rd_f(input logic [31:0] i);
    return i[11:7];
  endfunction

  function automatic logic is_mop(input logic [31:0] i);
    return (i[6:0] == OP) && (i[31:25] == FUNCT7_MULDIV);
  endfunction

  function automatic logic is_alu_op(input logic [31:0] i);
    return (i[6:0] == OP_IMM) || (i[6:0] == OP);
  endfunction

endpackage

// File: rtl/risc_v_exec_issue_lite_regfile.sv
// 32x32 register file: two combinational read ports, a debug read port, one synchronous write
// port; x0 reads as zero and is never written. RESET_REGFILE="TRUE" clears all entries on rst.
module risc_v_regfile_lite #(
  parameter string RESET_REGFILE = "TRUE"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  localparam bit CLR = (RESET_REGFILE == "TRUE");

  logic [31:0] mem [0:31];

  generate
    if (CLR) begin : g_clr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
          mem[waddr] <= wdata;
        end
      end
    end else begin : g_noclr
      always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) mem[waddr] <= wdata;
      end
    end
  endgenerate

  assign rd1      = (ra1 == 5'd0)      ? 32'd0 : mem[ra1];
  assign rd2      = (ra2 == 5'd0)      ? 32'd0 : mem[ra2];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : mem[dbg_addr];

endmodule

// File: rtl/risc_v_exec_issue_lite.sv
// Issue/write-back controller for the RV32I ALU: one instruction in flight, operand read, result
// write-back or trap. Define RISC_V_EXEC_ISSUE_MUL_WAIT_EN to give M-ops an extra EXEC_W cycle.
module risc_v_exec_issue_lite
  import risc_v_exec_issue_lite_pkg::*;
#(
  parameter string EXTENSION_M   = "FALSE",
  parameter string RESET_REGFILE = "TRUE"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  input  logic [31:0] alu_rd,
  input  logic        alu_fault,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [31:0] fault_inst,
  input  logic        fault_ack,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam bit M_EN = (EXTENSION_M == "TRUE");

  state_t      state, state_nx;
  logic [31:0] inst_q;
  logic [31:0] rf_rd1, rf_rd2;
  logic        exec_fault;
  logic        capture;

  risc_v_regfile_lite #(.RESET_REGFILE(RESET_REGFILE)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra1      (rs1_f(inst_q)),
    .ra2      (rs2_f(inst_q)),
    .dbg_addr (dbg_addr),
    .rd1      (rf_rd1),
    .rd2      (rf_rd2),
    .dbg_data (dbg_data),
    .we       (state == S_WB),
    .waddr    (wb_addr),
    .wdata    (wb_data)
  );

  // Illegal opcodes trap here even if the ALU fails to flag them.
  assign exec_fault = alu_fault || !is_alu_op(alu_instruction) ||
                      (is_mop(alu_instruction) && !M_EN);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (inst_valid) state_nx = S_READ;
      S_READ:  state_nx = S_EXEC;
      S_EXEC: begin
        if (exec_fault)                   state_nx = S_FAULT;
`ifdef RISC_V_EXEC_ISSUE_MUL_WAIT_EN
        else if (is_mop(alu_instruction)) state_nx = S_EXEC_W;
`endif
        else                              state_nx = S_WB;
      end
`ifdef RISC_V_EXEC_ISSUE_MUL_WAIT_EN
      S_EXEC_W: state_nx = alu_fault ? S_FAULT : S_WB;
`endif
      S_WB:    state_nx = S_IDLE;
      S_FAULT: if (fault_ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign inst_ready = (state == S_IDLE);
  assign fault      = (state == S_FAULT);
  assign capture    = ((state == S_EXEC) || (state == S_EXEC_W)) && (state_nx == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (inst_ready && inst_valid) inst_q <= inst;
  end

  // Outputs seen by the ALU and the retire interface; cleared on reset so nothing stale leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_instruction <= '0;
      alu_rs1         <= '0;
      alu_rs2         <= '0;
      wb_valid        <= 1'b0;
      wb_addr         <= '0;
      wb_data         <= '0;
      fault_inst      <= '0;
    end else begin
      wb_valid <= capture;
      if (state == S_READ) begin
        alu_instruction <= inst_q;
        alu_rs1         <= rf_rd1;
        alu_rs2         <= rf_rd2;
      end
      if (capture) begin
        wb_addr <= rd_f(alu_instruction);
        wb_data <= alu_rd;
      end
      if ((state_nx == S_FAULT) && (state != S_FAULT)) fault_inst <= inst_q;
    end
  end

endmodule

// File: tb/tb_risc_v_exec_issue_lite.sv
// Scoreboard bench: two instances (EXTENSION_M FALSE/TRUE) share stimulus, each has its own
// expected-event queue, and a negedge monitor checks every write-back pulse and fault entry.
module tb_risc_v_exec_issue_lite;

`ifdef RISC_V_EXEC_ISSUE_MUL_WAIT_EN
  localparam int MUL_LAT = 4;
`else
  localparam int MUL_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        fault_ack = 1'b0;
  logic [4:0]  dbg_addr = 5'd5;

  logic        inst_ready0, wb_valid0, fault0, alu_fault0;
  logic [31:0] alu_instruction0, alu_rs1_0, alu_rs2_0, alu_rd0, wb_data0, fault_inst0, dbg_data0;
  logic [4:0]  wb_addr0;
  logic        inst_ready1, wb_valid1, fault1, alu_fault1;
  logic [31:0] alu_instruction1, alu_rs1_1, alu_rs2_1, alu_rd1, wb_data1, fault_inst1, dbg_data1;
  logic [4:0]  wb_addr1;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic pf0 = 1'b0, pf1 = 1'b0;

  typedef struct {
    bit          flt;
    logic [4:0]  addr;
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Combinational reference ALU: ADDI, ADD, SUB, MUL; everything else is a decode fault.
  function automatic logic [32:0] alu(input logic [31:0] i, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] imm;
    imm = {{20{i[31]}}, i[31:20]};
    if (i[6:0] == 7'b0010011 && i[14:12] == 3'd0) return {1'b0, a + imm};
    if (i[6:0] == 7'b0110011 && i[14:12] == 3'd0) begin
      if (i[31:25] == 7'h00) return {1'b0, a + b};
      if (i[31:25] == 7'h20) return {1'b0, a - b};
      if (i[31:25] == 7'h01) return {1'b0, a * b};
    end
    return {1'b1, 32'd0};
  endfunction

  assign {alu_fault0, alu_rd0} = alu(alu_instruction0, alu_rs1_0, alu_rs2_0);
  assign {alu_fault1, alu_rd1} = alu(alu_instruction1, alu_rs1_1, alu_rs2_1);

  risc_v_exec_issue_lite dut0 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready0), .inst(inst),
    .alu_instruction(alu_instruction0), .alu_rs1(alu_rs1_0), .alu_rs2(alu_rs2_0),
    .alu_rd(alu_rd0), .alu_fault(alu_fault0), .wb_valid(wb_valid0), .wb_addr(wb_addr0),
    .wb_data(wb_data0), .fault(fault0), .fault_inst(fault_inst0), .fault_ack(fault_ack),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data0)
  );

  risc_v_exec_issue_lite #(.EXTENSION_M("TRUE")) dut1 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready1), .inst(inst),
    .alu_instruction(alu_instruction1), .alu_rs1(alu_rs1_1), .alu_rs2(alu_rs2_1),
    .alu_rd(alu_rd1), .alu_fault(alu_fault1), .wb_valid(wb_valid1), .wb_addr(wb_addr1),
    .wb_data(wb_data1), .fault(fault1), .fault_inst(fault_inst1), .fault_ack(fault_ack),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                     input logic rise, input logic [31:0] fi);
    exp_t e;
    if (!wv && !rise) return;
    if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected event: wb_valid=%0b fault_rise=%0b", d, wv, rise);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("dut%0d event_kind(fault)", d), {31'd0, rise}, {31'd0, e.flt});
    if (e.flt) begin
      chk($sformatf("dut%0d fault_inst", d), fi, e.data);
    end else begin
      chk($sformatf("dut%0d wb_addr", d), {27'd0, wa}, {27'd0, e.addr});
      chk($sformatf("dut%0d wb_data", d), wd, e.data);
    end
    // Latency counted as edges from the accept edge to the edge that closes this event's cycle.
    chk($sformatf("dut%0d latency", d), cyc - e.acc + 1, e.lat);
  endtask

  always @(negedge clk) begin
    mon(0, wb_valid0, wb_addr0, wb_data0, fault0 && !pf0, fault_inst0);
    mon(1, wb_valid1, wb_addr1, wb_data1, fault1 && !pf1, fault_inst1);
    pf0 <= fault0;
    pf1 <= fault1;
  end

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_ready0 && inst_ready1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_ready timeout: ready0=%0b ready1=%0b", inst_ready0, inst_ready1);
  endtask

  task automatic wait_fault();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fault0) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_fault timeout: fault0=%0b expected 1", fault0);
  endtask

  task automatic issue(input logic [31:0] w, input bit push, input bit f0, input logic [31:0] d0,
                       input bit f1, input logic [31:0] d1, input int l1);
    exp_t e;
    wait_ready();
    inst       = w;
    inst_valid = 1'b1;
    e.acc      = cyc + 1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    if (push) begin
      e.addr = w[11:7];
      e.flt  = f0;
      e.data = f0 ? w : d0;
      e.lat  = 3;
      q0.push_back(e);
      e.flt  = f1;
      e.data = f1 ? w : d1;
      e.lat  = f1 ? 3 : l1;
      q1.push_back(e);
    end
  endtask

  task automatic dbg_chk(input logic [4:0] a, input logic [31:0] e0, input logic [31:0] e1);
    dbg_addr = a;
    #1;
    chk($sformatf("dut0 dbg x%0d", a), dbg_data0, e0);
    chk($sformatf("dut1 dbg x%0d", a), dbg_data1, e1);
  endtask

  task automatic fault_hold_and_ack(input logic [31:0] w);
    repeat (2) begin
      @(negedge clk);
      chk("fault held", {31'd0, fault0}, 32'd1);
      chk("fault_inst held", fault_inst0, w);
    end
    fault_ack = 1'b1;
    @(posedge clk);
    #1 fault_ack = 1'b0;
    @(negedge clk);
    chk("ready after ack", {31'd0, inst_ready0}, 32'd1);
    chk("fault clear after ack", {31'd0, fault0}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst inst_ready", {31'd0, inst_ready0}, 32'd1);
    chk("rst wb_valid", {31'd0, wb_valid0}, 32'd0);
    chk("rst fault", {31'd0, fault0}, 32'd0);
    chk("rst alu_instruction", alu_instruction0, 32'd0);
    chk("rst wb_data", wb_data0, 32'd0);
    chk("rst fault_inst", fault_inst0, 32'd0);
    dbg_chk(5'd5, 32'd0, 32'd0);
    rst = 1'b0;

    // ADDI x5,x0,100; dbg shows old value during WB, new value afterwards
    issue(32'h06400293, 1'b1, 1'b0, 32'd100, 1'b0, 32'd100, 3);
    repeat (3) @(negedge clk);
    dbg_chk(5'd5, 32'd0, 32'd0);
    @(negedge clk);
    dbg_chk(5'd5, 32'd100, 32'd100);

    // ADDI x1,x0,7 ; SUB x2,x1,x1 ; ADD x3,x1,x1 back-to-back
    issue(32'h00700093, 1'b1, 1'b0, 32'd7, 1'b0, 32'd7, 3);
    issue(32'h40108133, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 3);
    issue(32'h001081B3, 1'b1, 1'b0, 32'd14, 1'b0, 32'd14, 3);
    wait_ready();
    dbg_chk(5'd2, 32'd0, 32'd0);
    dbg_chk(5'd3, 32'd14, 32'd14);

    // ADDI x0,x0,5: pulse with wb_addr=0, x0 stays zero
    issue(32'h00500013, 1'b1, 1'b0, 32'd5, 1'b0, 32'd5, 3);
    wait_ready();
    dbg_chk(5'd0, 32'd0, 32'd0);

    // JAL traps in both instances
    issue(32'h0000006F, 1'b1, 1'b1, 32'd0, 1'b1, 32'd0, 3);
    wait_fault();
    fault_hold_and_ack(32'h0000006F);

    // x1=6, x2=7, MUL x3,x1,x2: faults without M, 42 with M
    issue(32'h00600093, 1'b1, 1'b0, 32'd6, 1'b0, 32'd6, 3);
    issue(32'h00700113, 1'b1, 1'b0, 32'd7, 1'b0, 32'd7, 3);
    issue(32'h022081B3, 1'b1, 1'b1, 32'd0, 1'b0, 32'd42, MUL_LAT);
    wait_fault();
    fault_hold_and_ack(32'h022081B3);
    dbg_chk(5'd3, 32'd14, 32'd42);

    // Reset during EXEC of ADDI x9,x0,1 aborts it
    issue(32'h00100493, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst inst_ready0", {31'd0, inst_ready0}, 32'd1);
    chk("post-rst inst_ready1", {31'd0, inst_ready1}, 32'd1);
    chk("post-rst fault0", {31'd0, fault0}, 32'd0);
    dbg_chk(5'd9, 32'd0, 32'd0);

    repeat (6) @(negedge clk);
    chk("dut0 pending events", q0.size(), 32'd0);
    chk("dut1 pending events", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
